// File: rtl/adc_sampler_pkg.sv
// Shared types and helpers for the serial ADC reader: FSM state encoding and frame sizing.
package adc_sampler_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StConv  = 2'd1,
    StQuiet = 2'd2
  } adc_state_e;

  function automatic int unsigned frame_bits(input int unsigned lead_zeros,
                                             input int unsigned data_bits);
    return lead_zeros + data_bits;
  endfunction

endpackage

// File: rtl/adc_sampler_spi_rx_shift.sv
// Serial-in, parallel-out receive shift register: MSB arrives first, shifts in at the LSB end.
module adc_sampler_spi_rx_shift #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= {q[WIDTH-2:0], din};
    end
  end

endmodule

// File: rtl/adc_sampler.sv
// AD7476-class serial ADC reader: drives CS/SCLK, captures one frame per conversion and
// presents the payload with a single-cycle valid strobe and a leading-bit error flag.
module adc_sampler
  import adc_sampler_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 12,
  parameter int unsigned LEAD_ZEROS   = 4,
  parameter int unsigned QUIET_CYCLES = 2,
  parameter bit          FREE_RUN     = 1'b0
) (
  input  logic                 clk_10MHz,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 ad_sdata,
  output logic                 ad_cs,
  output logic                 ad_sclk,
  output logic [DATA_BITS-1:0] sample,
  output logic                 sample_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned FrameBits = frame_bits(LEAD_ZEROS, DATA_BITS);
  localparam int unsigned LastPhase = 2 * FrameBits - 1;
  localparam int unsigned PhaseW    = $clog2(2 * FrameBits) + 1;
  localparam int unsigned QuietW    = $clog2(QUIET_CYCLES + 2);
  // Free-running restarts straight from QUIET, so it stays one cycle longer to keep the
  // same frame period as a held start going through IDLE.
  localparam int unsigned QuietLast = FREE_RUN ? QUIET_CYCLES : QUIET_CYCLES - 1;

  adc_state_e           state_q;
  logic [PhaseW-1:0]    phase_q;
  logic [QuietW-1:0]    quiet_q;
  logic [FrameBits-1:0] shreg;
  logic                 shift_en;
  logic                 shift_clr;

  // Even phases end on an SCLK rising edge, which is when the data bit is stable.
  assign shift_en  = (state_q == StConv) && !phase_q[0];
  assign shift_clr = reset || (state_q != StConv);

  adc_sampler_spi_rx_shift #(
    .WIDTH(FrameBits)
  ) u_shift (
    .clk(clk_10MHz),
    .clr(shift_clr),
    .en (shift_en),
    .din(ad_sdata),
    .q  (shreg)
  );

  always_ff @(posedge clk_10MHz) begin
    if (reset) begin
      state_q      <= StIdle;
      phase_q      <= '0;
      quiet_q      <= '0;
      ad_cs        <= 1'b1;
      ad_sclk      <= 1'b1;
      sample       <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start || FREE_RUN) begin
            state_q <= StConv;
            phase_q <= '0;
            ad_cs   <= 1'b0;
            ad_sclk <= 1'b0;
            busy    <= 1'b1;
          end
        end
        StConv: begin
          if (phase_q == PhaseW'(LastPhase)) begin
            state_q      <= StQuiet;
            quiet_q      <= '0;
            ad_cs        <= 1'b1;
            ad_sclk      <= 1'b1;
            sample       <= shreg[DATA_BITS-1:0];
            frame_err    <= |shreg[FrameBits-1:DATA_BITS];
            sample_valid <= 1'b1;
          end else begin
            phase_q <= phase_q + PhaseW'(1);
            ad_sclk <= ~phase_q[0];
          end
        end
        StQuiet: begin
          if (quiet_q == QuietW'(QuietLast)) begin
            if (FREE_RUN) begin
              state_q <= StConv;
              phase_q <= '0;
              ad_cs   <= 1'b0;
              ad_sclk <= 1'b0;
            end else begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end
          end else begin
            quiet_q <= quiet_q + QuietW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sampler.sv
// Self-checking bench for adc_sampler: table of frames plus reset, ignored-start and free-run cases.
module tb_adc_sampler;

  logic        clk = 1'b0;
  always #50 clk = ~clk;

  logic        reset, start, sdata;
  logic        cs, sclk, valid, err, busy;
  logic [11:0] sample;

  logic        reset_fr, sdata_fr;
  logic        cs_fr, sclk_fr, valid_fr, err_fr, busy_fr;
  logic [11:0] sample_fr;

  int checks = 0;
  int errors = 0;

  adc_sampler dut (
    .clk_10MHz   (clk),
    .reset       (reset),
    .start       (start),
    .ad_sdata    (sdata),
    .ad_cs       (cs),
    .ad_sclk     (sclk),
    .sample      (sample),
    .sample_valid(valid),
    .frame_err   (err),
    .busy        (busy)
  );

  adc_sampler #(
    .FREE_RUN(1'b1)
  ) dut_fr (
    .clk_10MHz   (clk),
    .reset       (reset_fr),
    .start       (1'b0),
    .ad_sdata    (sdata_fr),
    .ad_cs       (cs_fr),
    .ad_sclk     (sclk_fr),
    .sample      (sample_fr),
    .sample_valid(valid_fr),
    .frame_err   (err_fr),
    .busy        (busy_fr)
  );

  // ADC models: next bit presented after each SCLK falling edge while CS is low.
  logic [15:0] frame_a = 16'h0;
  logic [4:0]  bit_a   = 5'd15;
  logic        prev_a  = 1'b1;
  always @(posedge clk) begin
    #1;
    if (cs !== 1'b0) begin
      bit_a = 5'd15;
    end else if (prev_a === 1'b1 && sclk === 1'b0 && bit_a <= 5'd15) begin
      sdata = frame_a[bit_a[3:0]];
      bit_a = bit_a - 5'd1;
    end
    prev_a = sclk;
  end

  logic [15:0] fr_val = 16'd1;
  logic [4:0]  bit_f  = 5'd15;
  logic        prev_f = 1'b1;
  always @(posedge clk) begin
    #1;
    if (cs_fr !== 1'b0) begin
      bit_f = 5'd15;
    end else if (prev_f === 1'b1 && sclk_fr === 1'b0 && bit_f <= 5'd15) begin
      sdata_fr = fr_val[bit_f[3:0]];
      if (bit_f == 5'd0) fr_val = fr_val + 16'd1;
      bit_f = bit_f - 5'd1;
    end
    prev_f = sclk_fr;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Start pulse at edge k, then observe cycles k+1..k+40.
  task automatic run_frame(input logic [15:0] fr, input logic [11:0] exp_s, input logic exp_e,
                           input bit noise);
    int          cs_bad, busy_bad, valid_bad, nvalid, rises;
    logic        prev_sclk;
    logic [11:0] got_s;
    logic        got_e;
    cs_bad = 0; busy_bad = 0; valid_bad = 0; nvalid = 0; rises = 0;
    got_s = 12'h0; got_e = 1'b0;
    frame_a = fr;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    prev_sclk = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      if (j > 1) @(negedge clk);
      start = noise && (j == 11 || j == 34);
      if (cs !== ((j <= 32) ? 1'b0 : 1'b1)) cs_bad++;
      if (busy !== ((j <= 34) ? 1'b1 : 1'b0)) busy_bad++;
      if (valid !== ((j == 33) ? 1'b1 : 1'b0)) valid_bad++;
      if (valid === 1'b1) begin
        nvalid++;
        got_s = sample;
        got_e = err;
      end
      if (prev_sclk === 1'b0 && sclk === 1'b1 && cs === 1'b0) rises++;
      prev_sclk = sclk;
    end
    start = 1'b0;
    check("cs_window", 32'(cs_bad), 32'd0);
    check("busy_window", 32'(busy_bad), 32'd0);
    check("valid_timing", 32'(valid_bad), 32'd0);
    check("valid_count", 32'(nvalid), 32'd1);
    check("sclk_rises", 32'(rises), 32'd16);
    check("sample", 32'(got_s), 32'(exp_s));
    check("frame_err", 32'(got_e), 32'(exp_e));
    check("sample_held", 32'(sample), 32'(exp_s));
  endtask

  typedef struct {
    logic [15:0] frame;
    logic [11:0] exp_sample;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{16'h0A5C, 12'hA5C, 1'b0};
    vecs[1] = '{16'h8FFF, 12'hFFF, 1'b1};
    vecs[2] = '{16'h0001, 12'h001, 1'b0};
    vecs[3] = '{16'hF000, 12'h000, 1'b1};
    vecs[4] = '{16'h0FFF, 12'hFFF, 1'b0};
    vecs[5] = '{16'h0444, 12'h444, 1'b0};

    reset = 1'b1; reset_fr = 1'b1; start = 1'b0; sdata = 1'b0; sdata_fr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_outputs", 32'({cs, sclk, valid, err, busy, sample}), 32'({5'b11000, 12'h0}));
    end
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_frame(vecs[i].frame, vecs[i].exp_sample, vecs[i].exp_err, 1'b0);

    // Start requests during CONV and QUIET must not queue a second frame.
    run_frame(16'h0C3A, 12'hC3A, 1'b0, 1'b1);

    // Reset at phase 20 aborts the frame.
    begin
      int nvalid, cs_low;
      frame_a = 16'h0FFF;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (20) @(negedge clk);
      check("cs_low_mid_frame", 32'(cs), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check("abort_outputs", 32'({cs, sclk, valid, err, busy, sample}),
            32'({5'b11000, 12'h0}));
      reset = 1'b0;
      nvalid = 0; cs_low = 0;
      for (int j = 0; j < 40; j++) begin
        @(negedge clk);
        if (valid === 1'b1) nvalid++;
        if (cs !== 1'b1) cs_low++;
      end
      check("abort_no_valid", 32'(nvalid), 32'd0);
      check("abort_stays_idle", 32'(cs_low), 32'd0);
    end
    run_frame(16'h0123, 12'h123, 1'b0, 1'b0);

    // Free-running instance: four back-to-back frames.
    begin
      int          vt[4];
      logic [11:0] vs[4];
      int          nv, hi_run, min_gap;
      bit          seen_low;
      nv = 0; hi_run = 0; min_gap = 1000; seen_low = 1'b0;
      for (int i = 0; i < 4; i++) begin
        vt[i] = 0;
        vs[i] = 12'h0;
      end
      @(negedge clk);
      reset_fr = 1'b0;
      for (int c = 0; c < 200 && nv < 4; c++) begin
        @(negedge clk);
        if (valid_fr === 1'b1) begin
          vt[nv] = c;
          vs[nv] = sample_fr;
          nv++;
        end
        if (cs_fr === 1'b0) begin
          if (seen_low && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
          seen_low = 1'b1;
          hi_run = 0;
        end else begin
          hi_run++;
        end
      end
      check("fr_pulses", 32'(nv), 32'd4);
      for (int i = 0; i < 4; i++) check("fr_sample", 32'(vs[i]), 32'(i + 1));
      for (int i = 1; i < 4; i++) check("fr_spacing", 32'(vt[i] - vt[i-1]), 32'd35);
      check("fr_cs_gap_ok", 32'(min_gap >= 2 && min_gap < 1000), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
